sync_fifo_prog: RTL and testbench
=================================

// Module: sync_fifo_prog
// PURPOSE
//  Parametrised single-clock FIFO, next generation of the team's sync FIFO.
//  Adds programmable almost-full/almost-empty thresholds, occupancy count, high-water mark,
//  synchronous flush, and a selectable standard / first-word-fall-through (FWFT) read mode.
//  Sits between a producer and a consumer in the same clock domain. Keeps the existing
//  handshake/status signal set.
// PARAMETERS
//  FIFO_WIDTH  16        data word width, >=1
//  FIFO_DEPTH  8         number of entries, >=2, need not be a power of 2
//  FIFO_MODE   FIFO_STD  fifo_mode_e: FIFO_STD (registered read) or FIFO_FWFT
//  CNT_W       $clog2(FIFO_DEPTH+1)  occupancy/threshold width (derived, do not override)
// PORTS
//  clk          in   1           clock, rising edge
//  rst_n        in   1           async active-low reset
//  flush        in   1           sync clear of contents
//  wr_en        in   1           write request
//  data_in      in   FIFO_WIDTH  write data
//  rd_en        in   1           read request (FWFT: pop head)
//  af_thresh    in   CNT_W       almostfull level, legal 1..FIFO_DEPTH
//  ae_thresh    in   CNT_W       almostempty level, legal 0..FIFO_DEPTH-1
//  data_out     out  FIFO_WIDTH  read data
//  wr_ack       out  1           write accepted (registered pulse)
//  overflow     out  1           write rejected (registered pulse)
//  underflow    out  1           read rejected (registered pulse)
//  full         out  1           count == FIFO_DEPTH
//  empty        out  1           count == 0
//  almostfull   out  1           count >= af_thresh
//  almostempty  out  1           count <= ae_thresh
//  count        out  CNT_W       current occupancy
//  max_count    out  CNT_W       high-water mark since reset/flush
// BEHAVIOUR
//  - Reset (rst_n=0, async): pointers, count, max_count, data_out, wr_ack, overflow, underflow = 0.
//    Memory is not cleared. Result: empty=1, almostempty=1, full=0, almostfull=0.
//    Reset mid-operation discards all contents.
//  - rd_acc = rd_en & !empty.
//  - wr_acc = wr_en & (!full | rd_acc): a write to a full FIFO succeeds only with an accepted read
//    in the same cycle.
//  - Next-cycle pulses: wr_ack = wr_acc; overflow = wr_en & !wr_acc; underflow = rd_en & !rd_acc.
//  - count += wr_acc - rd_acc. Simultaneous accept leaves count unchanged.
//  - On empty, a simultaneous wr+rd accepts the write and flags underflow.
//  - Pointers wrap explicitly from FIFO_DEPTH-1 to 0 (no power-of-2 reliance).
//  - full, empty, almostfull, almostempty are combinational from count and the threshold ports.
//    Threshold changes take effect the same cycle.
//  - max_count <= max(max_count, next count).
//  - STD mode: on rd_acc, data_out <= mem[rd_ptr] (latency 1). Otherwise data_out holds.
//  - FWFT mode: data_out = mem[rd_ptr] whenever !empty, visible the cycle after the write lands.
//    rd_acc advances the head. data_out holds its last value while empty.
//  - flush=1: next edge clears pointers, count and max_count; it overrides wr/rd.
//    wr_ack, overflow and underflow are 0 for that cycle. data_out holds.
//  - No internal state machine beyond the pointers and count.
// STRUCTURE
//  - fifo_pkg: typedef enum {FIFO_STD, FIFO_FWFT} fifo_mode_e; default width/depth localparams.
//  - Sub-module fifo_mem: FIFO_DEPTH x FIFO_WIDTH register array.
//    1 write port; 1 async read port addressed by rd_ptr.
//  - Pointer/count/flag logic stays in sync_fifo_prog.
// TESTING (WIDTH=16, DEPTH=8, af=6, ae=2 unless noted)
//  1. Write 0xA000..0xA007 -> wr_ack each cycle, full=1 after 8th.
//     9th write -> overflow=1, count=8.
//  2. rd_en on empty FIFO -> underflow=1 next cycle, data_out unchanged, count=0.
//  3. Full FIFO, wr_en=rd_en=1 with 0xBEEF -> both accepted, count stays 8.
//     0xBEEF read out 8th after 0xA000..0xA007 order.
//  4. Fill to 6 -> almostfull=1 at count 6 (0 at 5). Drain to 2 -> almostempty=1.
//     Change af to 4 at count 5 -> almostfull=1 same cycle.
//  5. FWFT: write 0x1234 to empty -> data_out=0x1234 next cycle without rd_en.
//     rd_en -> empty=1, data_out holds 0x1234.
//  6. Write 5 words, max_count=5. Then flush with wr_en=1 -> count=0, max_count=0, wr_ack=0.
//     Then rst_n pulse mid-write burst -> all outputs 0, empty=1.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and default sizes for the programmable sync FIFO family.
package fifo_pkg;

    // Read-side behaviour: registered read or first-word-fall-through.
    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    localparam int FIFO_WIDTH_DEF = 16;
    localparam int FIFO_DEPTH_DEF = 8;

endpackage

// File: rtl/fifo_mem.sv
// Storage array for the FIFO: one synchronous write port, one async read port.
// Contents are deliberately not reset; the pointers decide what is valid.
module fifo_mem #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write the accepted word into the slot addressed by the write pointer.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable almost-full/almost-empty levels,
// occupancy count, high-water mark, synchronous flush and STD/FWFT read modes.
module sync_fifo_prog
    import fifo_pkg::*;
#(
    parameter int         FIFO_WIDTH = FIFO_WIDTH_DEF,
    parameter int         FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter fifo_mode_e FIFO_MODE  = FIFO_STD,
    parameter int         CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [FIFO_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    input  logic [CNT_W-1:0]      af_thresh,
    input  logic [CNT_W-1:0]      ae_thresh,
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic                  wr_ack,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  full,
    output logic                  empty,
    output logic                  almostfull,
    output logic                  almostempty,
    output logic [CNT_W-1:0]      count,
    output logic [CNT_W-1:0]      max_count
);

    localparam int               PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

    // Pointers wrap explicitly so that non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    logic [PTR_W-1:0]      wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]      rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [CNT_W-1:0]      maxCount_q, maxCount_d;
    logic [FIFO_WIDTH-1:0] data_q, data_d;
    logic                  wrAck_q, wrAck_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic                  fullS, emptyS;
    logic                  rdAcc, wrAcc;
    logic [FIFO_WIDTH-1:0] rdData;

    fifo_mem #(
        .WIDTH  (FIFO_WIDTH),
        .DEPTH  (FIFO_DEPTH),
        .ADDR_W (PTR_W)
    ) uMem (
        .clk     (clk),
        .we_i    (wrAcc),
        .waddr_i (wrPtr_q),
        .wdata_i (data_in),
        .raddr_i (rdPtr_q),
        .rdata_o (rdData)
    );

    // Status flags are purely combinational from occupancy and live thresholds.
    always_comb begin
        fullS       = (count_q == DEPTH_C);
        emptyS      = (count_q == '0);
        almostfull  = (count_q >= af_thresh);
        almostempty = (count_q <= ae_thresh);
    end

    // Accept decisions; flush blocks both sides so nothing moves that cycle.
    always_comb begin
        rdAcc = rd_en & ~emptyS & ~flush;
        wrAcc = wr_en & (~fullS | rdAcc) & ~flush;
    end

    // Next-state for pointers, occupancy, high-water mark, read data and pulses.
    always_comb begin
        wrPtr_d     = wrPtr_q;
        rdPtr_d     = rdPtr_q;
        count_d     = count_q;
        maxCount_d  = maxCount_q;
        data_d      = data_q;
        wrAck_d     = 1'b0;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;

        if (FIFO_MODE == FIFO_FWFT) begin
            if (!emptyS) begin
                data_d = rdData;
            end
        end else if (rdAcc) begin
            data_d = rdData;
        end

        if (flush) begin
            wrPtr_d    = '0;
            rdPtr_d    = '0;
            count_d    = '0;
            maxCount_d = '0;
        end else begin
            if (wrAcc) begin
                wrPtr_d = ptrInc(wrPtr_q);
            end
            if (rdAcc) begin
                rdPtr_d = ptrInc(rdPtr_q);
            end
            case ({wrAcc, rdAcc})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            maxCount_d  = (count_d > maxCount_q) ? count_d : maxCount_q;
            wrAck_d     = wrAcc;
            overflow_d  = wr_en & ~wrAcc;
            underflow_d = rd_en & ~rdAcc;
        end
    end

    // State register with asynchronous active-low reset; memory is left alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            count_q     <= '0;
            maxCount_q  <= '0;
            data_q      <= '0;
            wrAck_q     <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            count_q     <= count_d;
            maxCount_q  <= maxCount_d;
            data_q      <= data_d;
            wrAck_q     <= wrAck_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // In FWFT the head word shows directly; otherwise the held register is shown.
    always_comb begin
        if (FIFO_MODE == FIFO_FWFT && !emptyS) begin
            data_out = rdData;
        end else begin
            data_out = data_q;
        end
    end

    assign wr_ack    = wrAck_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
    assign full      = fullS;
    assign empty     = emptyS;
    assign count     = count_q;
    assign max_count = maxCount_q;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Bench for sync_fifo_prog: a STD and an FWFT instance share one stimulus stream
// and are compared against a queue-based reference model.
module tb_sync_fifo_prog;
    import fifo_pkg::*;

    localparam int W  = 16;
    localparam int D  = 8;
    localparam int CW = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          rstN = 1'b0;
    logic          flush = 1'b0;
    logic          wrEn = 1'b0;
    logic          rdEn = 1'b0;
    logic [W-1:0]  dataIn = '0;
    logic [CW-1:0] afTh = CW'(6);
    logic [CW-1:0] aeTh = CW'(2);

    logic [W-1:0]  sDout, fDout;
    logic          sAck, sOvf, sUdf, sFull, sEmpty, sAf, sAe;
    logic          fAck, fOvf, fUdf, fFull, fEmpty, fAf, fAe;
    logic [CW-1:0] sCount, sMax, fCount, fMax;

    sync_fifo_prog #(.FIFO_WIDTH(W), .FIFO_DEPTH(D), .FIFO_MODE(FIFO_STD)) dutStd (
        .clk(clk), .rst_n(rstN), .flush(flush), .wr_en(wrEn), .data_in(dataIn),
        .rd_en(rdEn), .af_thresh(afTh), .ae_thresh(aeTh), .data_out(sDout),
        .wr_ack(sAck), .overflow(sOvf), .underflow(sUdf), .full(sFull), .empty(sEmpty),
        .almostfull(sAf), .almostempty(sAe), .count(sCount), .max_count(sMax)
    );

    sync_fifo_prog #(.FIFO_WIDTH(W), .FIFO_DEPTH(D), .FIFO_MODE(FIFO_FWFT)) dutFwft (
        .clk(clk), .rst_n(rstN), .flush(flush), .wr_en(wrEn), .data_in(dataIn),
        .rd_en(rdEn), .af_thresh(afTh), .ae_thresh(aeTh), .data_out(fDout),
        .wr_ack(fAck), .overflow(fOvf), .underflow(fUdf), .full(fFull), .empty(fEmpty),
        .almostfull(fAf), .almostempty(fAe), .count(fCount), .max_count(fMax)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state: contents as a queue, plus what each read mode shows.
    logic [W-1:0] mq[$];
    int           mMax;
    logic [W-1:0] mStd;
    logic [W-1:0] mLast;
    logic         mAck, mOvf, mUdf;

    function automatic logic [W-1:0] expFwft();
        return (mq.size() > 0) ? mq[0] : mLast;
    endfunction

    function automatic void resetModel();
        mq.delete();
        mMax  = 0;
        mStd  = '0;
        mLast = '0;
        mAck  = 1'b0;
        mOvf  = 1'b0;
        mUdf  = 1'b0;
    endfunction

    // Drive one clock cycle of stimulus and advance the model by the same cycle.
    task automatic applyStimulus(input logic wr, input logic [W-1:0] din,
                                 input logic rd, input logic fl);
        bit ra, wa;
        @(negedge clk);
        wrEn   = wr;
        dataIn = din;
        rdEn   = rd;
        flush  = fl;
        if (mq.size() > 0) mLast = mq[0];
        if (fl) begin
            mq.delete();
            mMax = 0;
            mAck = 1'b0;
            mOvf = 1'b0;
            mUdf = 1'b0;
        end else begin
            ra = rd && (mq.size() > 0);
            wa = wr && ((mq.size() < D) || ra);
            if (ra) mStd = mq.pop_front();
            if (wa) mq.push_back(din);
            mAck = wa;
            mOvf = wr && !wa;
            mUdf = rd && !ra;
            if (mq.size() > mMax) mMax = mq.size();
        end
        @(posedge clk);
        #1;
        wrEn  = 1'b0;
        rdEn  = 1'b0;
        flush = 1'b0;
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        resetModel();
        #3;
        total++; if (sCount !== '0) begin bad++; $display("[TB] FAIL reset_count: got %0d expected 0", sCount); end
        total++; if (sEmpty !== 1'b1 || sAe !== 1'b1) begin bad++; $display("[TB] FAIL reset_empty: got empty=%b ae=%b expected 1 1", sEmpty, sAe); end
        total++; if (sFull !== 1'b0 || sAf !== 1'b0) begin bad++; $display("[TB] FAIL reset_full: got full=%b af=%b expected 0 0", sFull, sAf); end
        total++; if (sDout !== '0 || fDout !== '0) begin bad++; $display("[TB] FAIL reset_dout: got std=%h fwft=%h expected 0 0", sDout, fDout); end
        total++; if ({sAck, sOvf, sUdf, sMax} !== '0) begin bad++; $display("[TB] FAIL reset_pulses: got ack=%b ovf=%b udf=%b max=%0d expected 0", sAck, sOvf, sUdf, sMax); end
        @(negedge clk);
        rstN = 1'b1;
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < D; i++) begin
            applyStimulus(1'b1, 16'hA000 + 16'(i), 1'b0, 1'b0);
            total++;
            if (sAck !== 1'b1 || sCount !== CW'(i + 1)) begin
                bad++; $display("[TB] FAIL fill_%0d: got ack=%b count=%0d expected 1 %0d", i, sAck, sCount, i + 1);
            end
        end
        total++; if (sFull !== 1'b1) begin bad++; $display("[TB] FAIL fill_full: got %b expected 1", sFull); end
        applyStimulus(1'b1, 16'hDEAD, 1'b0, 1'b0);
        total++;
        if (sOvf !== 1'b1 || sAck !== 1'b0 || sCount !== CW'(D)) begin
            bad++; $display("[TB] FAIL overflow: got ovf=%b ack=%b count=%0d expected 1 0 %0d", sOvf, sAck, sCount, D);
        end
    endtask

    task automatic test_full_rw_underflow();
        logic [W-1:0] order [D];
        for (int i = 0; i < D - 1; i++) order[i] = 16'hA001 + 16'(i);
        order[D-1] = 16'hBEEF;
        applyStimulus(1'b1, 16'hBEEF, 1'b1, 1'b0);
        total++;
        if (sAck !== 1'b1 || sCount !== CW'(D) || sDout !== 16'hA000 || fDout !== 16'hA001) begin
            bad++; $display("[TB] FAIL full_rw: got ack=%b count=%0d std=%h fwft=%h expected 1 %0d a000 a001", sAck, sCount, sDout, fDout, D);
        end
        for (int i = 0; i < D; i++) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b0);
            total++;
            if (sDout !== order[i] || sDout !== mStd) begin
                bad++; $display("[TB] FAIL drain_%0d: got %h expected %h", i, sDout, order[i]);
            end
        end
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        total++;
        if (sUdf !== 1'b1 || sDout !== 16'hBEEF || sCount !== '0 || fDout !== 16'hBEEF) begin
            bad++; $display("[TB] FAIL underflow: got udf=%b std=%h count=%0d fwft=%h expected 1 beef 0 beef", sUdf, sDout, sCount, fDout);
        end
    endtask

    task automatic test_thresholds();
        afTh = CW'(6);
        aeTh = CW'(2);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0);
        total++; if (sAf !== 1'b0) begin bad++; $display("[TB] FAIL af_at5: got %b expected 0", sAf); end
        applyStimulus(1'b1, 16'h0105, 1'b0, 1'b0);
        total++; if (sAf !== 1'b1) begin bad++; $display("[TB] FAIL af_at6: got %b expected 1", sAf); end
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
        total++; if (sAe !== 1'b0 || sCount !== CW'(3)) begin bad++; $display("[TB] FAIL ae_at3: got ae=%b count=%0d expected 0 3", sAe, sCount); end
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        total++; if (sAe !== 1'b1) begin bad++; $display("[TB] FAIL ae_at2: got %b expected 1", sAe); end
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 16'h0200 + 16'(i), 1'b0, 1'b0);
        total++; if (sAf !== 1'b0 || sCount !== CW'(5)) begin bad++; $display("[TB] FAIL af_before_change: got af=%b count=%0d expected 0 5", sAf, sCount); end
        afTh = CW'(4);
        #1;
        total++; if (sAf !== 1'b1 || fAf !== 1'b1) begin bad++; $display("[TB] FAIL af_change: got std=%b fwft=%b expected 1 1", sAf, fAf); end
        afTh = CW'(6);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
    endtask

    task automatic test_fwft();
        applyStimulus(1'b1, 16'h1234, 1'b0, 1'b0);
        total++;
        if (fDout !== 16'h1234 || fCount !== CW'(1) || sDout !== mStd) begin
            bad++; $display("[TB] FAIL fwft_show: got fwft=%h count=%0d std=%h expected 1234 1 %h", fDout, fCount, sDout, mStd);
        end
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        total++;
        if (fEmpty !== 1'b1 || fDout !== 16'h1234 || sDout !== 16'h1234) begin
            bad++; $display("[TB] FAIL fwft_pop: got empty=%b fwft=%h std=%h expected 1 1234 1234", fEmpty, fDout, sDout);
        end
    endtask

    task automatic test_flush_reset();
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 16'($urandom), 1'b0, 1'b0);
        total++; if (sMax !== CW'(5)) begin bad++; $display("[TB] FAIL max_5: got %0d expected 5", sMax); end
        applyStimulus(1'b1, 16'h5555, 1'b0, 1'b1);
        total++;
        if (sCount !== '0 || sMax !== '0 || sAck !== 1'b0 || fAck !== 1'b0 || sEmpty !== 1'b1) begin
            bad++; $display("[TB] FAIL flush: got count=%0d max=%0d ack=%b/%b empty=%b expected 0 0 0/0 1", sCount, sMax, sAck, fAck, sEmpty);
        end
        applyStimulus(1'b1, 16'h7001, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h7002, 1'b0, 1'b0);
        @(negedge clk);
        wrEn   = 1'b1;
        dataIn = 16'h7003;
        rstN   = 1'b0;
        resetModel();
        #2;
        total++;
        if (sCount !== '0 || sMax !== '0 || sDout !== '0 || fDout !== '0 || {sAck, sOvf, sUdf} !== 3'b000 || sEmpty !== 1'b1) begin
            bad++; $display("[TB] FAIL mid_reset: got count=%0d max=%0d std=%h fwft=%h ack=%b empty=%b expected all 0, empty 1", sCount, sMax, sDout, fDout, sAck, sEmpty);
        end
        @(negedge clk);
        wrEn = 1'b0;
        rstN = 1'b1;
    endtask

    task automatic test_random();
        logic [4*CW+8+W-1:0] expS, obsS, expF, obsF;
        int sz;
        for (int c = 0; c < 600; c++) begin
            bit fillPhase;
            fillPhase = ((c / 40) % 2) == 0;
            if ($urandom_range(0, 9) == 0) begin
                afTh = CW'($urandom_range(1, D));
                aeTh = CW'($urandom_range(0, D - 1));
            end
            applyStimulus($urandom_range(0, 99) < (fillPhase ? 80 : 35), 16'($urandom),
                          $urandom_range(0, 99) < (fillPhase ? 35 : 80),
                          $urandom_range(0, 99) < 2);
            sz   = mq.size();
            expS = {CW'(sz), CW'(mMax), CW'(sz), CW'(mMax), sz == D, sz == 0,
                    CW'(sz) >= afTh, CW'(sz) <= aeTh, mAck, mOvf, mUdf, 1'b0, mStd};
            obsS = {sCount, sMax, fCount, fMax, sFull, sEmpty, sAf, sAe, sAck, sOvf, sUdf, 1'b0, sDout};
            expF = {CW'(sz), CW'(mMax), CW'(sz), CW'(mMax), sz == D, sz == 0,
                    CW'(sz) >= afTh, CW'(sz) <= aeTh, mAck, mOvf, mUdf, 1'b0, expFwft()};
            obsF = {fCount, fMax, fCount, fMax, fFull, fEmpty, fAf, fAe, fAck, fOvf, fUdf, 1'b0, fDout};
            total++;
            if (obsS !== expS) begin bad++; $display("[TB] FAIL rand_std_%0d: got %h expected %h", c, obsS, expS); end
            total++;
            if (obsF !== expF) begin bad++; $display("[TB] FAIL rand_fwft_%0d: got %h expected %h", c, obsF, expF); end
        end
    endtask

    // Run every scenario in order, then report.
    initial begin
        test_reset();
        test_fill_overflow();
        test_full_rw_underflow();
        test_thresholds();
        test_fwft();
        test_flush_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
